// File: rtl/stage_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// stage_sequencer_pkg
//   Shared definitions for the stage sequencer core: the state encoding seen
//   on the state output, the default wait timeout used by fetch/mem control,
//   and small helpers that classify states.
// -----------------------------------------------------------------------------
package stage_sequencer_pkg;

    // Encoding is architecturally visible on the state output, so values are
    // pinned explicitly rather than left to the enum default ordering.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_IDLE   = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } state_e;

    // Maximum wait cycles in FETCH or MEM before giving up.
    localparam logic [7:0]  DEFAULT_TIMEOUT = 8'd255;

    // Sequential instructions are one word apart.
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // States in which an instruction is in flight.
    function automatic logic is_busy(input state_e s);
        case (s)
            ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB: is_busy = 1'b1;
            default:                                     is_busy = 1'b0;
        endcase
    endfunction

    // States that wait on an external ready and are guarded by the timer.
    function automatic logic is_wait_state(input state_e s);
        is_wait_state = (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// -----------------------------------------------------------------------------
// stage_sequencer_if
//   Bundles the control/handshake signals of the stage sequencer.
//   master : the sequencer side (drives requests, strobes and status)
//   slave  : the environment side (drives start/halt, ready and decode info)
//
//   start, halt_req         run control into the sequencer
//   fetch_req / fetch_ready instruction fetch handshake
//   mem_access              decoded "uses data memory" flag, sampled in EXEC
//   mem_req / mem_ready     data memory handshake
//   reg_write, reg_write_en decoded write enable and the qualified WB strobe
//   branch_taken/addr       branch resolution, sampled in WB
//   state, pc, retired      architectural status
//   busy, err               instruction in flight / sticky error
// -----------------------------------------------------------------------------
interface stage_sequencer_if;

    logic        start;
    logic        halt_req;
    logic        fetch_req;
    logic        fetch_ready;
    logic        mem_access;
    logic        mem_req;
    logic        mem_ready;
    logic        reg_write;
    logic        reg_write_en;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        busy;
    logic        err;

    modport master (
        input  start, halt_req, fetch_ready, mem_access, mem_ready,
               reg_write, branch_taken, branch_addr,
        output fetch_req, mem_req, reg_write_en, state, pc, retired,
               busy, err
    );

    modport slave (
        output start, halt_req, fetch_ready, mem_access, mem_ready,
               reg_write, branch_taken, branch_addr,
        input  fetch_req, mem_req, reg_write_en, state, pc, retired,
               busy, err
    );

endinterface

// File: rtl/stage_sequencer_wait_timer.sv
// -----------------------------------------------------------------------------
// wait_timer
//   Counts cycles spent waiting for ready in FETCH or MEM and flags a timeout.
//   The count is held at zero whenever the sequencer is outside a wait state,
//   so it is always zero on entry to FETCH or MEM.
//
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   active_i   sequencer is in a wait state (FETCH or MEM)
//   ready_i    the ready belonging to the current wait state
//   expired_o  count has reached TIMEOUT and ready is still absent; ready in
//              the same cycle suppresses it
// -----------------------------------------------------------------------------
module wait_timer
    import stage_sequencer_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic ready_i,
    output logic expired_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // NOTE: every signal written here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = 8'd0;
        if (active_i && !ready_i) begin
            count_d = count_q + 8'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Once the count equals TIMEOUT the sequencer leaves for ERROR, so the
    // counter never has to run past TIMEOUT.
    assign expired_o = active_i && !ready_i && (count_q == TIMEOUT);

endmodule

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//   Multi-cycle instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC ->
//   [MEM] -> WB -> FETCH ... with a sticky halt request, a wait timeout on
//   FETCH/MEM and a terminal ERROR state left only through rst.
//
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (forces IDLE, pc=RESET_PC)
//   bus   stage_sequencer_if.master, see the interface for signal roles
//
//   Parameters
//   RESET_PC  pc value after reset
//   TIMEOUT   maximum wait cycles in FETCH or MEM before ERROR
// -----------------------------------------------------------------------------
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    stage_sequencer_if.master   bus
);

    state_e      state_q;
    state_e      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] retired_q;
    logic [31:0] retired_d;
    logic        halt_q;
    logic        halt_d;

    logic        fetch_req;
    logic        mem_req;
    logic        reg_write_en;

    logic        wait_active;
    logic        wait_ready;
    logic        wait_expired;
    logic        bad_branch;

    // -------------------------------------------------------------------------
    // Wait timeout for FETCH / MEM. The ready that matters depends on which
    // wait state we are in; readies in any other state are ignored.
    // -------------------------------------------------------------------------
    assign wait_active = is_wait_state(state_q);
    assign wait_ready  = (state_q == ST_FETCH) ? bus.fetch_ready : bus.mem_ready;

    wait_timer #(
        .TIMEOUT   (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .active_i  (wait_active),
        .ready_i   (wait_ready),
        .expired_o (wait_expired)
    );

    // A taken branch to a non-word-aligned target cannot be fetched.
    assign bad_branch = bus.branch_taken && (bus.branch_addr[1:0] != 2'b00);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        retired_d    = retired_q;
        halt_d       = halt_q;
        fetch_req    = 1'b0;
        mem_req      = 1'b0;
        reg_write_en = 1'b0;

        // Halt requests are only remembered while an instruction is in flight.
        if (is_busy(state_q) && bus.halt_req) begin
            halt_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                fetch_req = 1'b1;
                if (bus.fetch_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_ERROR;
                end
            end

            ST_DECODE: begin
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                state_d = bus.mem_access ? ST_MEM : ST_WB;
            end

            ST_MEM: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    state_d = ST_WB;
                end else if (wait_expired) begin
                    state_d = ST_ERROR;
                end
            end

            ST_WB: begin
                if (bad_branch) begin
                    // Instruction does not retire: no write, pc/retired held.
                    state_d = ST_ERROR;
                end else begin
                    reg_write_en = bus.reg_write;
                    pc_d         = bus.branch_taken ? bus.branch_addr
                                                    : pc_q + INSTR_BYTES;
                    retired_d    = retired_q + 32'd1;
                    state_d      = halt_q ? ST_HALT : ST_FETCH;
                end
            end

            ST_ERROR: begin
                state_d = ST_ERROR;
            end

            default: begin
                state_d = ST_ERROR;
            end
        endcase

        // The latch is consumed by the transition into HALT.
        if (state_d == ST_HALT) begin
            halt_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            retired_q <= 32'd0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            halt_q    <= halt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Requests and strobes are decoded from the current state only,
    // so at most one of them can be high and all drop as soon as rst forces
    // IDLE.
    // -------------------------------------------------------------------------
    assign bus.fetch_req    = fetch_req;
    assign bus.mem_req      = mem_req;
    assign bus.reg_write_en = reg_write_en;
    assign bus.state        = state_q;
    assign bus.pc           = pc_q;
    assign bus.retired      = retired_q;
    assign bus.busy         = is_busy(state_q);
    assign bus.err          = (state_q == ST_ERROR);

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//   Directed self-checking bench for stage_sequencer (TIMEOUT=4, RESET_PC=0).
//   Inputs are driven 1 time unit after the rising edge and outputs are
//   sampled there, away from the active edge.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;
    import stage_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    stage_sequencer_if bus ();

    stage_sequencer #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (8'd4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start        = 1'b0;
        bus.halt_req     = 1'b0;
        bus.fetch_ready  = 1'b0;
        bus.mem_access   = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.reg_write    = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_addr  = 32'd0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Leave IDLE/HALT: start for one cycle, expect FETCH at exp_pc.
    task automatic start_run(input string tag, input logic [31:0] exp_pc);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_state"}, 32'(bus.state), 32'(ST_FETCH));
        check({tag, "_fetch_req"}, 32'(bus.fetch_req), 32'd1);
        check({tag, "_pc"}, bus.pc, exp_pc);
    endtask

    // Runs one instruction starting in FETCH with fetch_ready immediately.
    task automatic do_instr(input string tag, input logic mem_a,
                            input int mem_waits, input logic br,
                            input logic [31:0] baddr, input logic rw,
                            input logic halt_in_decode, input logic exp_rwe,
                            input logic [31:0] exp_pc, input logic [31:0] exp_ret,
                            input state_e exp_next);
        bus.fetch_ready = 1'b1;
        tick();
        bus.fetch_ready = 1'b0;
        check({tag, "_decode"}, 32'(bus.state), 32'(ST_DECODE));
        bus.halt_req = halt_in_decode;
        tick();
        bus.halt_req = 1'b0;
        check({tag, "_exec"}, 32'(bus.state), 32'(ST_EXEC));
        bus.mem_access = mem_a;
        tick();
        bus.mem_access = 1'b0;
        if (mem_a) begin
            for (int i = 0; i <= mem_waits; i++) begin
                check({tag, "_mem_state"}, 32'(bus.state), 32'(ST_MEM));
                check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd1);
                check({tag, "_mem_fetch_req"}, 32'(bus.fetch_req), 32'd0);
                bus.mem_ready = (i == mem_waits);
                tick();
            end
            bus.mem_ready = 1'b0;
        end
        check({tag, "_wb"}, 32'(bus.state), 32'(ST_WB));
        bus.branch_taken = br;
        bus.branch_addr  = baddr;
        bus.reg_write    = rw;
        #1;
        check({tag, "_rwe"}, 32'(bus.reg_write_en), 32'(exp_rwe));
        check({tag, "_wb_mem_req"}, 32'(bus.mem_req), 32'd0);
        tick();
        bus.branch_taken = 1'b0;
        bus.branch_addr  = 32'd0;
        bus.reg_write    = 1'b0;
        check({tag, "_next"}, 32'(bus.state), 32'(exp_next));
        check({tag, "_pc"}, bus.pc, exp_pc);
        check({tag, "_retired"}, bus.retired, exp_ret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        clear_inputs();
        rst = 1'b1;
        #2;
        check("rst_state", 32'(bus.state), 32'(ST_IDLE));
        check("rst_pc", bus.pc, 32'h0);
        check("rst_retired", bus.retired, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
        tick();
        rst = 1'b0;

        // fetch_ready in IDLE is ignored
        bus.fetch_ready = 1'b1;
        tick();
        bus.fetch_ready = 1'b0;
        check("idle_ignore_ready", 32'(bus.state), 32'(ST_IDLE));

        // ---- T1: simple ALU instruction: 5,0,1,2,4,0 ----
        start_run("t1_start", 32'h0);
        check("t1_busy", 32'(bus.busy), 32'd1);
        do_instr("t1", 1'b0, 0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1,
                 32'h4, 32'd1, ST_FETCH);

        // ---- T2: aligned branch, then misaligned branch -> ERROR ----
        do_instr("t2a", 1'b0, 0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1,
                 32'h40, 32'd2, ST_FETCH);
        do_instr("t2b", 1'b0, 0, 1'b1, 32'h42, 1'b1, 1'b0, 1'b0,
                 32'h40, 32'd2, ST_ERROR);
        check("t2_err", 32'(bus.err), 32'd1);
        check("t2_busy", 32'(bus.busy), 32'd0);
        check("t2_fetch_req", 32'(bus.fetch_req), 32'd0);
        bus.start     = 1'b1;
        bus.halt_req  = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        clear_inputs();
        check("t2_error_hold", 32'(bus.state), 32'(ST_ERROR));
        check("t2_error_pc", bus.pc, 32'h40);

        // ---- T3: memory instruction with 3 wait cycles ----
        apply_reset();
        start_run("t3_start", 32'h0);
        do_instr("t3", 1'b1, 3, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1,
                 32'h4, 32'd1, ST_FETCH);

        // ---- T4a: fetch_ready never arrives -> ERROR after 5 FETCH cycles ----
        for (int i = 0; i < 5; i++) begin
            check("t4a_fetch_wait", 32'(bus.state), 32'(ST_FETCH));
            tick();
        end
        check("t4a_timeout", 32'(bus.state), 32'(ST_ERROR));
        check("t4a_err", 32'(bus.err), 32'd1);

        // ---- T4b: ready on the 5th FETCH cycle wins over the timeout ----
        apply_reset();
        start_run("t4b_start", 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("t4b_fifth_cycle", 32'(bus.state), 32'(ST_FETCH));
        bus.fetch_ready = 1'b1;
        tick();
        bus.fetch_ready = 1'b0;
        check("t4b_decode", 32'(bus.state), 32'(ST_DECODE));
        tick();
        tick();
        tick();
        check("t4b_next_fetch", 32'(bus.state), 32'(ST_FETCH));
        check("t4b_pc", bus.pc, 32'h4);

        // ---- T5: halt_req pulsed in DECODE ----
        do_instr("t5", 1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0,
                 32'h8, 32'd2, ST_HALT);
        check("t5_busy", 32'(bus.busy), 32'd0);
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        check("t5_halt_hold", 32'(bus.state), 32'(ST_HALT));
        start_run("t5_restart", 32'h8);
        // latch must have cleared: the next instruction does not halt
        do_instr("t5b", 1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
                 32'hC, 32'd3, ST_FETCH);

        // ---- T6: rst asserted in the middle of MEM ----
        bus.fetch_ready = 1'b1;
        tick();
        bus.fetch_ready = 1'b0;
        tick();
        bus.mem_access = 1'b1;
        tick();
        bus.mem_access = 1'b0;
        check("t6_in_mem", 32'(bus.state), 32'(ST_MEM));
        check("t6_mem_req", 32'(bus.mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_state", 32'(bus.state), 32'(ST_IDLE));
        check("t6_rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("t6_rst_pc", bus.pc, 32'h0);
        check("t6_rst_retired", bus.retired, 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_after_rst", 32'(bus.state), 32'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The block SHALL have these parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- TIMEOUT, 8'd255, maximum wait cycles in FETCH or MEM before ERROR.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
REQ-003 The block SHALL have these other ports:
- start         in   1   leave IDLE/HALT, begin fetching
- halt_req      in   1   stop after current instruction retires
- fetch_req     out  1   instruction fetch request
- fetch_ready   in   1   fetch data valid this cycle
- mem_access    in   1   decoded instruction uses data memory (sampled in EXEC)
- mem_req       out  1   data memory request
- mem_ready     in   1   data memory access complete this cycle
- reg_write     in   1   decoded register-write enable
- reg_write_en  out  1   register-file write strobe
- branch_taken  in   1   branch resolved taken (sampled in WB)
- branch_addr   in   32  branch target
- state         out  3   current state encoding
- pc            out  32  current instruction address
- retired       out  32  retired-instruction count
- busy          out  1   high in FETCH/DECODE/EXEC/MEM/WB
- err           out  1   high in ERROR

Function
REQ-004 State encoding SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, IDLE=5, HALT=6, ERROR=7.
REQ-005 IDLE/HALT: start=1 -> FETCH next edge; otherwise hold.
REQ-006 FETCH: fetch_req=1 combinationally; fetch_ready=1 -> DECODE next edge.
REQ-007 DECODE -> EXEC unconditionally after one cycle.
REQ-008 EXEC: mem_access=1 -> MEM, else WB.
REQ-009 MEM: mem_req=1 combinationally; mem_ready=1 -> WB next edge.
REQ-010 WB, one cycle:
- reg_write_en=reg_write.
- pc <= branch_taken ? branch_addr : pc+4, modulo 2^32.
- retired increments, modulo 2^32.
- Next state is HALT if the halt latch is set, else FETCH.
REQ-011 Minimum latency SHALL be 4 cycles per non-memory instruction and 5 per memory instruction, each plus ready wait cycles.
REQ-012 halt_req SHALL set a sticky halt latch in any busy state; the latch SHALL clear on entering HALT; halt_req in IDLE/HALT/ERROR SHALL be ignored.
REQ-013 start while busy or in ERROR SHALL be ignored.
REQ-014 A wait counter SHALL clear on entry to FETCH/MEM and increment each cycle without ready; if ready is absent when the count equals TIMEOUT, the next state SHALL be ERROR; ready in that same cycle wins.
REQ-015 In WB, branch_taken=1 with branch_addr[1:0]!=0 SHALL go to ERROR with pc, retired unchanged and reg_write_en=0.
REQ-016 ERROR SHALL be held until rst; all request/strobe outputs SHALL be 0 there.
REQ-017 fetch_ready/mem_ready outside FETCH/MEM SHALL be ignored.
REQ-018 fetch_req, mem_req and reg_write_en SHALL never be high simultaneously.

Reset
REQ-019 rst SHALL immediately force state=IDLE, pc=RESET_PC, retired=0, halt latch=0, wait counter=0, with all strobes, busy and err at 0, including mid-handshake.
REQ-020 The first rising edge after rst deasserts SHALL be evaluated as IDLE.

Structure
REQ-021 The state encodings and the default TIMEOUT SHALL live in a shared core package used by fetch/mem control.
REQ-022 The wait counter with its timeout compare SHALL be one sub-module, wait_timer.

Verification
REQ-023 Bench SHALL cover:
- Reset, start, fetch_ready=1 immediately, mem_access=0, no branch -> state 5,0,1,2,4,0; pc 0->4; retired=1.
- Branch in WB with branch_addr=0x40 -> pc=0x40; with branch_addr=0x42 -> ERROR, pc unchanged, err=1.
- mem_access=1, mem_ready after 3 wait cycles -> mem_req high 4 cycles, then WB with reg_write_en=reg_write.
- TIMEOUT=4, fetch_ready never asserted -> ERROR after 5 FETCH cycles; ready on the 5th cycle -> DECODE instead.
- halt_req pulsed in DECODE -> instruction retires, state=HALT, pc advanced; start -> FETCH at the new pc.
- rst asserted mid-MEM -> immediate IDLE, mem_req=0, pc=RESET_PC.
